board_m: RTL and testbench

Game-state holder for the tic-tac-toe design: the consumer of the `update_loc` / `update_val` / `reset` stream that the stimulus generator drives. Stores the nine cells and enforces turn order and legality. Detects wins and draws, and reports each rejected move with a one-cycle error pulse and code. Sits between the move source and any display or checker logic.

---
 rtl/board_m.sv | 95 +++++++++
 tb/tb_board_m.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/board_m.sv
// Tic-tac-toe board state holder: stores nine cells, enforces turn order and
// legality, detects wins and draws, and flags rejected moves with a code.
module board_m (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  update_loc,
  input  logic [1:0]  update_val,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  game_state,
  output logic [3:0]  move_count,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [1:0] {PLAYING = 2'd0, X_WIN = 2'd1, O_WIN = 2'd2, DRAW = 2'd3} game_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_GAME_OVER = 3'd1, ERR_BAD_VAL = 3'd2,
    ERR_BAD_LOC = 3'd3, ERR_WRONG_TURN = 3'd4, ERR_OCCUPIED = 3'd5
  } err_t;

  game_t       state;
  logic [3:0]  last_loc;
  logic [1:0]  last_val;
  logic        request;
  err_t        check;
  logic [4:0]  bit_idx;
  logic [17:0] next_board;
  logic        mover_wins;

  // Only the mover can complete a line, so testing the mover's mark suffices.
  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] hit;
    hit = '0;
    for (int i = 0; i < 9; i++) hit[i] = (b[2*i +: 2] == m);
    return (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
           (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
           (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
           (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
  endfunction

  assign game_state = state;
  assign bit_idx    = {update_loc, 1'b0};

  always_comb begin
    request    = (update_val != CELL_EMPTY) &&
                 ((update_loc != last_loc) || (update_val != last_val));
    check      = ERR_NONE;
    next_board = board;
    if (state != PLAYING)              check = ERR_GAME_OVER;
    else if (update_val == 2'b11)      check = ERR_BAD_VAL;
    else if (update_loc > 4'd8)        check = ERR_BAD_LOC;
    else if (update_val != turn)       check = ERR_WRONG_TURN;
    else if (board[bit_idx +: 2] != CELL_EMPTY) check = ERR_OCCUPIED;
    if (update_loc <= 4'd8) next_board[bit_idx +: 2] = update_val;
    mover_wins = has_line(next_board, update_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board      <= '0;
      turn       <= CELL_X;
      state      <= PLAYING;
      move_count <= 4'd0;
      err        <= 1'b0;
      err_code   <= 3'd0;
      last_loc   <= 4'd0;
      last_val   <= CELL_EMPTY;
    end else begin
      last_loc <= update_loc;
      last_val <= update_val;
      err      <= 1'b0;
      if (request) begin
        if (check != ERR_NONE) begin
          err      <= 1'b1;
          err_code <= check;
        end else begin
          board      <= next_board;
          move_count <= move_count + 4'd1;
          turn       <= (turn == CELL_X) ? CELL_O : CELL_X;
          if (mover_wins)
            state <= (update_val == CELL_X) ? X_WIN : O_WIN;
          else if (move_count == 4'd8)
            state <= DRAW;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_m.sv
// Bench for board_m: directed game scenarios with literal checks, then random
// play compared every cycle against an array-based model of the game rules.
module tb_board_m;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  update_loc = 4'd0;
  logic [1:0]  update_val = 2'd0;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [1:0]  game_state;
  logic [3:0]  move_count;
  logic        err;
  logic [2:0]  err_code;

  int vectors = 0;
  int miscompares = 0;
  bit compare_en = 1'b0;

  // Model state: cell contents as an array, plain integers for everything else.
  int m_cells [9];
  int m_turn = 1, m_state = 0, m_count = 0, m_err = 0, m_code = 0;
  int m_last_loc = 0, m_last_val = 0;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  board_m dut (
    .clk(clk), .reset(reset), .update_loc(update_loc), .update_val(update_val),
    .board(board), .turn(turn), .game_state(game_state), .move_count(move_count),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic bit model_wins(int mark);
    for (int l = 0; l < 8; l++)
      if (m_cells[lines[l][0]] == mark && m_cells[lines[l][1]] == mark &&
          m_cells[lines[l][2]] == mark) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cells[i][1:0];
    return b;
  endfunction

  always @(posedge clk) begin
    int code, loc, val;
    loc = update_loc;
    val = update_val;
    if (reset) begin
      for (int i = 0; i < 9; i++) m_cells[i] = 0;
      m_turn = 1; m_state = 0; m_count = 0; m_err = 0; m_code = 0;
      m_last_loc = 0; m_last_val = 0;
    end else begin
      m_err = 0;
      if (val != 0 && !(loc == m_last_loc && val == m_last_val)) begin
        code = 0;
        if (m_state != 0)               code = 1;
        else if (val == 3)              code = 2;
        else if (loc > 8)               code = 3;
        else if (val != m_turn)         code = 4;
        else if (m_cells[loc] != 0)     code = 5;
        if (code != 0) begin
          m_err = 1;
          m_code = code;
        end else begin
          m_cells[loc] = val;
          m_count++;
          m_turn = 3 - m_turn;
          if (model_wins(val)) m_state = val;
          else if (m_count == 9) m_state = 3;
        end
      end
      m_last_loc = loc;
      m_last_val = val;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (compare_en) begin
      check_output("board",      int'(board),      int'(model_board()));
      check_output("turn",       int'(turn),       m_turn);
      check_output("game_state", int'(game_state), m_state);
      check_output("move_count", int'(move_count), m_count);
      check_output("err",        int'(err),        m_err);
      check_output("err_code",   int'(err_code),   m_code);
    end
  end

  task automatic apply_stimulus(input bit rst, input int loc, input int val);
    @(negedge clk);
    reset = rst;
    update_loc = 4'(loc);
    update_val = 2'(val);
    @(posedge clk);
    #2;
  endtask

  task automatic play(input int seq[$]);
    foreach (seq[i]) apply_stimulus(1'b0, seq[i] % 10, (seq[i] >= 10) ? 2 : 1);
  endtask

  initial begin
    int loc, val;
    for (int i = 0; i < 9; i++) m_cells[i] = 0;

    apply_stimulus(1'b1, 0, 0);
    compare_en = 1'b1;
    check_output("rst_state", int'(game_state), 0);
    check_output("rst_err", int'(err), 0);
    check_output("rst_code", int'(err_code), 0);

    // O moves first: wrong turn
    apply_stimulus(1'b0, 0, 2);
    check_output("o_first_err", int'(err), 1);
    check_output("o_first_code", int'(err_code), 4);
    check_output("o_first_board", int'(board), 0);
    check_output("o_first_turn", int'(turn), 1);
    check_output("o_first_count", int'(move_count), 0);

    apply_stimulus(1'b0, 0, 1);
    check_output("x0_cell", int'(board[1:0]), 1);
    check_output("x0_turn", int'(turn), 2);
    check_output("x0_count", int'(move_count), 1);
    check_output("x0_err", int'(err), 0);

    apply_stimulus(1'b0, 8, 1);
    check_output("x8_code", int'(err_code), 4);
    apply_stimulus(1'b0, 9, 1);
    check_output("loc9_code", int'(err_code), 3);
    check_output("loc9_err", int'(err), 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 9, 1);
      check_output("held_err", int'(err), 0);
    end

    apply_stimulus(1'b0, 0, 2);
    check_output("occupied_code", int'(err_code), 5);
    play('{14, 1, 15, 2});
    check_output("x_win", int'(game_state), 1);
    apply_stimulus(1'b0, 6, 2);
    check_output("over_code", int'(err_code), 1);
    check_output("over_err", int'(err), 1);
    check_output("over_board", int'(board), 32'h00A15);

    apply_stimulus(1'b1, 0, 0);
    play('{0, 11, 2, 14, 3, 15, 7, 16, 8});
    check_output("draw_state", int'(game_state), 3);
    check_output("draw_count", int'(move_count), 9);
    check_output("draw_turn", int'(turn), 2);

    apply_stimulus(1'b1, 0, 0);
    play('{0, 11, 2, 14});
    check_output("mid_count", int'(move_count), 4);
    apply_stimulus(1'b1, 3, 1);
    check_output("midrst_count", int'(move_count), 0);
    check_output("midrst_board", int'(board), 0);
    check_output("midrst_turn", int'(turn), 1);
    apply_stimulus(1'b0, 3, 1);
    check_output("after_rst_board", int'(board), 32'h00040);
    check_output("after_rst_count", int'(move_count), 1);

    // Random play, biased toward legal moves so games actually finish
    loc = 0; val = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(99);
      if (r < 2 || (m_state != 0 && r < 15)) begin
        apply_stimulus(1'b1, $urandom_range(15), $urandom_range(3));
        continue;
      end
      if (r < 20) begin
        // keep previous inputs
      end else if (r < 30) begin
        val = 0;
      end else begin
        loc = ($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(8);
        val = ($urandom_range(9) < 7) ? m_turn : $urandom_range(3);
      end
      apply_stimulus(1'b0, loc, val);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
